zigzag_pingpong: RTL and testbench
==================================

// Module: zigzag_pingpong
// PURPOSE
//  Streaming 8x8 coefficient reorder, placed between the quantiser and the run-length/entropy coder.
//  Accepts one raster-order block (row-major, index = row*8+col) as 64/LANES beats.
//  Emits the block in JPEG zigzag order, or unchanged raster order, selectable per block.
//  Two ping-pong banks give sustained 1 beat/cycle throughput.
//  Valid/ready handshakes on both sides.
// PARAMETERS
//  BW     12  coefficient width in bits (signed two's complement; block does no arithmetic on values)
//  LANES  8   coefficients per beat; legal values 1,2,4,8; BEATS = 64/LANES
// PORTS
//  i_clk      in   1         clock
//  i_Reset    in   1         reset, synchronous, active-low
//  i_data     in   LANES*BW  input beat; lane 0 in MSBs [LANES*BW-1 -: BW]
//  i_valid    in   1         input beat valid
//  o_ready    out  1         block can accept input beat
//  i_mode     in   1         0 = zigzag, 1 = raster bypass; sampled with first beat of block
//  o_data     out  LANES*BW  output beat; lane 0 in MSBs
//  o_valid    out  1         output beat valid
//  i_ready    in   1         downstream accepts output beat
//  o_first    out  1         o_data is beat 0 of a block
//  o_last     out  1         o_data is beat BEATS-1 of a block
//  o_eob_pos  out  6         (ZZ_STATS_EN only) last nonzero output position of block
//  o_eob_none out  1         (ZZ_STATS_EN only) block entirely zero
// BEHAVIOUR
//  - Reset (i_Reset=0 at posedge): both banks EMPTY, wr_bank=rd_bank=0, beat counters 0.
//    o_valid/o_first/o_last/o_data/o_eob_* = 0; o_ready=0 while i_Reset=0.
//    Bank storage is not reset.
//  - Input beat accepted when i_valid & o_ready.
//    Beat b lane l writes raster index b*LANES+l of bank wr_bank.
//    i_mode is latched into the bank's mode bit on b=0.
//  - o_ready = ~full[wr_bank] (combinational from registered state).
//  - Accepting beat BEATS-1 sets full[wr_bank], toggles wr_bank and clears the write counter.
//  - Output register loads when full[rd_bank] & (~o_valid | i_ready).
//    Output position p = j*LANES+l for beat j, lane l.
//    Mode 0: source raster index ZZ_ORDER[p]. Mode 1: source raster index p.
//  - Loading beat BEATS-1 clears full[rd_bank] and toggles rd_bank.
//    The writer may use that bank from the next cycle.
//  - If no load occurs and i_ready=1, o_valid drops.
//    While o_valid & ~i_ready, o_data/o_first/o_last/o_eob_* hold stable.
//  - Latency: last input beat accepted in cycle t -> o_valid=1 with beat 0 in cycle t+2.
//    With i_ready held 1, beats are contiguous and back-to-back blocks show no bubble after the first.
//  - Bank state per bank: EMPTY -> FILLING (first beat) -> FULL (last beat) -> DRAINING (first load)
//    -> EMPTY (last load).
//    Set and clear of different banks in the same cycle both take effect.
//    A bank is never written while FULL or DRAINING.
//  - Both banks full: o_ready=0 until the drain of rd_bank completes; no beat is lost or overwritten.
//  - i_valid=0 mid-block: the write counter holds; the partial block waits indefinitely.
//  - Reset mid-operation discards partial and full blocks; the first block after reset is clean.
// CONFIGURATION
//  ZZ_STATS_EN defined:
//   - o_eob_pos/o_eob_none are present.
//   - A running "highest nonzero position" over output positions p (mode order) updates on each load
//     and restarts at beat 0.
//   - Values are valid, including the current beat, when o_last=1; they are 0 otherwise.
//   - o_eob_none=1 and o_eob_pos=0 if all 64 coefficients are 0.
//  ZZ_STATS_EN undefined: ports and logic are absent; all other behaviour is identical.
// STRUCTURE
//  - zigzag_pkg holds:
//    - localparam BLK=64;
//    - ZZ_ORDER[0:63], 6-bit raster index per zigzag position (0,1,8,16,9,2,3,10,17,24,...,63);
//    - bank state enum {EMPTY,FILLING,FULL,DRAINING}.
//  - Sub-module zigzag_bank, instantiated twice:
//    - 64xBW storage with a LANES-wide write at beat address;
//    - LANES parallel read ports at arbitrary 6-bit indices;
//    - plus the mode bit.
// TESTING
//  1. LANES=8, mode 0, coeff = raster index 0..63
//     -> beat0 {0,1,8,16,9,2,3,10} with o_first; beat1 {17,24,32,25,18,11,4,5}; beat7 ends ...,62,63 with o_last.
//  2. Three blocks back-to-back, i_ready=1 -> o_ready never low; 24 contiguous output beats; first o_valid at t+2.
//  3. i_ready=0 for 30 cycles with 3 blocks offered -> o_ready falls after block 2 completes;
//     o_data stable while stalled; all 3 blocks output correctly.
//  4. Blocks alternating mode 1,0,1, LANES=1 -> raster blocks pass unchanged, zigzag block reordered;
//     o_first/o_last pulse on single beats.
//  5. Reset after 3 input beats and again while draining -> all outputs 0, o_ready=1 the cycle after release;
//     next block exact, no stale data.
//  6. ZZ_STATS_EN, mode 0, only raster 17 nonzero -> o_eob_pos=8, none=0 at o_last;
//     all-zero block -> o_eob_pos=0, o_eob_none=1.

Source files
------------

// File: rtl/zigzag_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zigzag_pkg
// Purpose  : Shared constants and types for the zigzag ping-pong reorder.
//            BLK      - coefficients per 8x8 block
//            ZZ_ORDER - raster index read for each zigzag output position
//            bank_state_t - lifecycle of one ping-pong bank
// Revision : 1.0 - initial release
// ============================================================================
package zigzag_pkg;

  localparam int BLK = 64;

  localparam logic [5:0] ZZ_ORDER [0:63] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  // A bank holding a complete block (waiting or being read) is closed to the writer.
  function automatic logic bank_full(input bank_state_t s);
    return (s == FULL) || (s == DRAINING);
  endfunction

endpackage
`default_nettype wire

// File: rtl/zigzag_bank.sv
`default_nettype none
// ============================================================================
// Module   : zigzag_bank
// Purpose  : One ping-pong bank: 64 x BW coefficient store with a LANES-wide
//            write at a beat address, LANES independent combinational read
//            ports, and the block's mode bit.
// Ports    : i_clk      clock
//            i_we       write LANES coefficients at beat i_waddr
//            i_waddr    beat address (raster index = i_waddr*LANES + lane)
//            i_wdata    write beat, lane 0 in MSBs
//            i_mode_we  capture i_mode (first beat of a block)
//            i_mode     0 = zigzag, 1 = raster bypass
//            i_raddr    LANES 6-bit read indices, lane 0 in MSBs
//            o_rdata    LANES read coefficients, lane 0 in MSBs
//            o_mode     stored mode bit
// Revision : 1.0 - initial release
// ============================================================================
module zigzag_bank #(
  parameter int BW     = 12,
  parameter int LANES  = 8,
  parameter int BEAT_W = 3
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [BEAT_W-1:0]     i_waddr,
  input  logic [LANES*BW-1:0]   i_wdata,
  input  logic                  i_mode_we,
  input  logic                  i_mode,
  input  logic [LANES*6-1:0]    i_raddr,
  output logic [LANES*BW-1:0]   o_rdata,
  output logic                  o_mode
);

  localparam int LANE_SH = $clog2(LANES);

  // Storage is deliberately not reset: a block is always fully written
  // before any of it is read.
  logic [BW-1:0] r_mem [0:63];
  logic          r_mode;
  logic [5:0]    w_base;

  assign w_base = 6'(i_waddr) << LANE_SH;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int l = 0; l < LANES; l++) begin
        r_mem[w_base | 6'(l)] <= i_wdata[(LANES-l)*BW-1 -: BW];
      end
    end
    if (i_mode_we) begin
      r_mode <= i_mode;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_rd
    assign o_rdata[(LANES-l)*BW-1 -: BW] = r_mem[i_raddr[(LANES-l)*6-1 -: 6]];
  end

  assign o_mode = r_mode;

endmodule
`default_nettype wire

// File: rtl/zigzag_pingpong.sv
`default_nettype none
// ============================================================================
// Module   : zigzag_pingpong
// Purpose  : Streaming 8x8 coefficient reorder. Accepts a raster-order block
//            as 64/LANES beats and emits it in JPEG zigzag order (mode 0) or
//            unchanged (mode 1). Two banks alternate so one fills while the
//            other drains, sustaining one beat per cycle.
// Ports    : i_clk      clock
//            i_Reset    synchronous reset, active low
//            i_data     input beat, lane 0 in MSBs
//            i_valid    input beat valid
//            o_ready    input beat can be accepted
//            i_mode     0 = zigzag, 1 = raster; sampled with beat 0
//            o_data     output beat, lane 0 in MSBs
//            o_valid    output beat valid
//            i_ready    downstream accepts output beat
//            o_first    o_data is beat 0 of a block
//            o_last     o_data is the final beat of a block
//            o_eob_pos  highest nonzero output position (ZZ_STATS_EN)
//            o_eob_none block entirely zero (ZZ_STATS_EN)
// Config   : define ZZ_STATS_EN to add the end-of-block statistics outputs.
// Revision : 1.0 - initial release
// ============================================================================
module zigzag_pingpong
  import zigzag_pkg::*;
#(
  parameter int BW    = 12,
  parameter int LANES = 8
) (
  input  logic                  i_clk,
  input  logic                  i_Reset,
  input  logic [LANES*BW-1:0]   i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_mode,
  output logic [LANES*BW-1:0]   o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_first,
  output logic                  o_last
`ifdef ZZ_STATS_EN
  ,
  output logic [5:0]            o_eob_pos,
  output logic                  o_eob_none
`endif
);

  localparam int                BEATS     = BLK / LANES;
  localparam int                BEAT_W    = $clog2(BEATS);
  localparam int                LANE_SH   = $clog2(LANES);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  bank_state_t         r_state [2];
  logic                r_wr_bank;
  logic                r_rd_bank;
  logic [BEAT_W-1:0]   r_wr_cnt;
  logic [BEAT_W-1:0]   r_rd_cnt;

  logic [1:0]          w_full;
  logic [1:0]          w_mode;
  logic [LANES*BW-1:0] w_rdata [2];
  logic [LANES*BW-1:0] w_sel_data;
  logic [LANES*6-1:0]  w_raddr;
  logic [5:0]          w_pos [LANES];
  logic                w_wr_acc;
  logic                w_wr_last;
  logic                w_ld;
  logic                w_ld_last;

  assign o_ready   = i_Reset & ~w_full[r_wr_bank];
  assign w_wr_acc  = i_valid & o_ready;
  assign w_wr_last = w_wr_acc & (r_wr_cnt == LAST_BEAT);
  assign w_ld      = w_full[r_rd_bank] & (~o_valid | i_ready);
  assign w_ld_last = w_ld & (r_rd_cnt == LAST_BEAT);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic w_we;
    assign w_we      = w_wr_acc & (r_wr_bank == 1'(b));
    assign w_full[b] = bank_full(r_state[b]);

    zigzag_bank #(
      .BW     (BW),
      .LANES  (LANES),
      .BEAT_W (BEAT_W)
    ) u_bank (
      .i_clk     (i_clk),
      .i_we      (w_we),
      .i_waddr   (r_wr_cnt),
      .i_wdata   (i_data),
      .i_mode_we (w_we & (r_wr_cnt == '0)),
      .i_mode    (i_mode),
      .i_raddr   (w_raddr),
      .o_rdata   (w_rdata[b]),
      .o_mode    (w_mode[b])
    );
  end

  // Output position of each lane in the beat being loaded, and the raster
  // index it is fetched from in the draining bank's mode.
  for (genvar l = 0; l < LANES; l++) begin : g_addr
    assign w_pos[l] = (6'(r_rd_cnt) << LANE_SH) | 6'(l);
    assign w_raddr[(LANES-l)*6-1 -: 6] =
      w_mode[r_rd_bank] ? w_pos[l] : ZZ_ORDER[w_pos[l]];
  end

  assign w_sel_data = w_rdata[r_rd_bank];

`ifdef ZZ_STATS_EN
  logic       w_beat_any;
  logic [5:0] w_beat_hi;
  logic       w_run_any;
  logic [5:0] w_run_pos;
  logic       r_acc_any;
  logic [5:0] r_acc_pos;

  // Highest lane wins, so the last nonzero lane gives the beat's top position.
  always_comb begin
    w_beat_any = 1'b0;
    w_beat_hi  = '0;
    for (int l = 0; l < LANES; l++) begin
      if (w_sel_data[(LANES-l)*BW-1 -: BW] != '0) begin
        w_beat_any = 1'b1;
        w_beat_hi  = w_pos[l];
      end
    end
  end

  // Beat 0 restarts the running value instead of folding in the previous block.
  assign w_run_any = w_beat_any | (r_acc_any & (r_rd_cnt != '0));
  assign w_run_pos = w_beat_any ? w_beat_hi :
                     ((r_rd_cnt != '0) ? r_acc_pos : 6'd0);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_Reset) begin
      r_state[0] <= EMPTY;
      r_state[1] <= EMPTY;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_first    <= 1'b0;
      o_last     <= 1'b0;
`ifdef ZZ_STATS_EN
      r_acc_any  <= 1'b0;
      r_acc_pos  <= '0;
      o_eob_pos  <= '0;
      o_eob_none <= 1'b0;
`endif
    end else begin
      if (w_wr_acc) begin
        if (w_wr_last) begin
          r_wr_cnt  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_cnt  <= r_wr_cnt + 1'b1;
        end
      end

      if (w_ld) begin
        o_data  <= w_sel_data;
        o_valid <= 1'b1;
        o_first <= (r_rd_cnt == '0);
        o_last  <= (r_rd_cnt == LAST_BEAT);
`ifdef ZZ_STATS_EN
        r_acc_any  <= w_run_any;
        r_acc_pos  <= w_run_pos;
        o_eob_pos  <= (r_rd_cnt == LAST_BEAT) ? w_run_pos : 6'd0;
        o_eob_none <= (r_rd_cnt == LAST_BEAT) ? ~w_run_any : 1'b0;
`endif
        if (w_ld_last) begin
          r_rd_cnt  <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_rd_cnt  <= r_rd_cnt + 1'b1;
        end
      end else if (i_ready) begin
        o_valid <= 1'b0;
        o_first <= 1'b0;
        o_last  <= 1'b0;
`ifdef ZZ_STATS_EN
        o_eob_pos  <= '0;
        o_eob_none <= 1'b0;
`endif
      end

      // Writer and reader never touch the same bank in one cycle, so both
      // updates can land together.
      for (int b = 0; b < 2; b++) begin
        if (w_wr_acc && (r_wr_bank == 1'(b))) begin
          r_state[b] <= w_wr_last ? FULL : FILLING;
        end
        if (w_ld && (r_rd_bank == 1'(b))) begin
          r_state[b] <= w_ld_last ? EMPTY : DRAINING;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zigzag_pingpong.sv
`default_nettype none
// ============================================================================
// Module   : tb_zigzag_pingpong
// Purpose  : Scoreboard bench for zigzag_pingpong. One instance with LANES=8
//            and one with LANES=1 share clock and reset. Expected beats are
//            queued when a block is issued; monitors pop and compare on each
//            output handshake. Define ZZ_STATS_EN to also compare o_eob_*.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zigzag_pingpong;

  typedef struct {
    logic [95:0] d;
    logic        f;
    logic        l;
    logic [5:0]  pos;
    logic        none;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;

  logic [95:0] din8 = '0;
  logic        v8 = 1'b0, m8 = 1'b0, ir8 = 1'b1;
  logic        rdy8, ov8, f8, l8;
  logic [95:0] d8;
  logic [11:0] din1 = '0;
  logic        v1 = 1'b0, m1 = 1'b0, ir1 = 1'b1;
  logic        rdy1, ov1, f1, l1;
  logic [11:0] d1;
`ifdef ZZ_STATS_EN
  logic [5:0]  ep8, ep1;
  logic        en8, en1;
`endif

  exp_t        q8[$];
  exp_t        q1[$];
  exp_t        e8, e1;
  int          n_vec = 0, n_err = 0;
  int          zz[64];
  logic [11:0] blk[64];

  int          pops8 = 0, gaps8 = 0, gap_base = 0, first_v_cyc = -1;
  bit          gap_arm = 1'b0;
  int          blocks8 = 0, waits8 = 0;
  bit          held = 1'b0;
  logic [95:0] hold_d;
  logic [1:0]  hold_fl;

  zigzag_pingpong #(.BW(12), .LANES(8)) dut8 (
    .i_clk(clk), .i_Reset(rst_n), .i_data(din8), .i_valid(v8), .o_ready(rdy8),
    .i_mode(m8), .o_data(d8), .o_valid(ov8), .i_ready(ir8), .o_first(f8), .o_last(l8)
`ifdef ZZ_STATS_EN
    , .o_eob_pos(ep8), .o_eob_none(en8)
`endif
  );

  zigzag_pingpong #(.BW(12), .LANES(1)) dut1 (
    .i_clk(clk), .i_Reset(rst_n), .i_data(din1), .i_valid(v1), .o_ready(rdy1),
    .i_mode(m1), .o_data(d1), .o_valid(ov1), .i_ready(ir1), .o_first(f1), .o_last(l1)
`ifdef ZZ_STATS_EN
    , .o_eob_pos(ep1), .o_eob_none(en1)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Zigzag walk over anti-diagonals: even diagonals run up-right, odd down-left.
  task automatic build_zz();
    int p = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz[p] = r * 8 + (s - r); p++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz[p] = r * 8 + (s - r); p++; end
      end
    end
  endtask

  function automatic logic [11:0] pat(input int kind, input int i);
    case (kind)
      0: return 12'(i);
      1: return 12'(100 + i);
      2: return 12'(i * 37) ^ 12'h800;
      3: return 12'(-i);
      4: return 12'(i * i + 5);
      5: return (i == 17) ? 12'd5 : 12'd0;
      6: return 12'd0;
      7: return 12'(i * 3);
      8: return 12'(700 - i);
      default: return 12'hABC;
    endcase
  endfunction

  task automatic fill(input int kind);
    for (int i = 0; i < 64; i++) blk[i] = pat(kind, i);
  endtask

  task automatic push_exp(input int lanes, input logic m);
    exp_t        e;
    int          hi = 0;
    bit          any = 1'b0;
    logic [11:0] v;
    for (int j = 0; j < 64 / lanes; j++) begin
      e.d = '0;
      for (int l = 0; l < lanes; l++) begin
        int p = j * lanes + l;
        v = m ? blk[p] : blk[zz[p]];
        e.d = (e.d << 12) | 96'(v);
        if (v != 12'd0) begin any = 1'b1; hi = p; end
      end
      e.f    = (j == 0);
      e.l    = (j == 64 / lanes - 1);
      e.pos  = e.l ? 6'(hi) : 6'd0;
      e.none = e.l ? !any : 1'b0;
      if (lanes == 8) q8.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic send8(input logic [95:0] d, input logic m);
    bit acc = 1'b0;
    int w = 0;
    v8 = 1'b1; din8 = d; m8 = m;
    while (!acc) begin
      @(negedge clk);
      acc = rdy8;
      if (!acc) w++;
      @(posedge clk); #1;
      if (w > 300) begin
        n_vec++; n_err++;
        $display("FAIL dut8 input timeout: o_ready stayed 0 for %0d cycles, required 1", w);
        break;
      end
    end
    v8 = 1'b0;
    waits8 += w;
  endtask

  task automatic send1(input logic [11:0] d, input logic m);
    bit acc = 1'b0;
    int w = 0;
    v1 = 1'b1; din1 = d; m1 = m;
    while (!acc) begin
      @(negedge clk);
      acc = rdy1;
      @(posedge clk); #1;
      w++;
      if (w > 300) begin
        n_vec++; n_err++;
        $display("FAIL dut1 input timeout: o_ready stayed 0, required 1");
        break;
      end
    end
    v1 = 1'b0;
  endtask

  task automatic send_block8(input logic m);
    logic [95:0] beat;
    push_exp(8, m);
    for (int j = 0; j < 8; j++) begin
      beat = '0;
      for (int l = 0; l < 8; l++) beat = (beat << 12) | 96'(blk[j * 8 + l]);
      send8(beat, m);
    end
    blocks8++;
  endtask

  task automatic send_block1(input logic m);
    push_exp(1, m);
    for (int j = 0; j < 64; j++) send1(blk[j], m);
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((q8.size() != 0 || q1.size() != 0) && g < 500) begin
      @(posedge clk); #1; g++;
    end
    check("drain complete (beats left)", 96'(q8.size() + q1.size()), 96'd0);
  endtask

  // Monitor for the 8-lane instance.
  always @(negedge clk) begin
    if (held && ov8) begin
      check("dut8 data held while stalled", d8, hold_d);
      check("dut8 first/last held while stalled", 96'({f8, l8}), 96'(hold_fl));
    end
    held    = ov8 && !ir8;
    hold_d  = d8;
    hold_fl = {f8, l8};
    if (gap_arm && ov8 && first_v_cyc < 0) first_v_cyc = cyc;
    if (gap_arm && !ov8 && pops8 > gap_base && pops8 < gap_base + 24) gaps8++;
    if (ov8 && ir8) begin
      if (q8.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL dut8 unexpected beat: got %h, required no output", d8);
      end else begin
        e8 = q8.pop_front();
        check("dut8 data", d8, e8.d);
        check("dut8 first/last", 96'({f8, l8}), 96'({e8.f, e8.l}));
`ifdef ZZ_STATS_EN
        check("dut8 eob pos/none", 96'({ep8, en8}), 96'({e8.pos, e8.none}));
`endif
      end
      pops8++;
    end
  end

  // Monitor for the 1-lane instance.
  always @(negedge clk) begin
    if (ov1 && ir1) begin
      if (q1.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL dut1 unexpected beat: got %h, required no output", d1);
      end else begin
        e1 = q1.pop_front();
        check("dut1 data", 96'(d1), e1.d);
        check("dut1 first/last", 96'({f1, l1}), 96'({e1.f, e1.l}));
`ifdef ZZ_STATS_EN
        check("dut1 eob pos/none", 96'({ep1, en1}), 96'({e1.pos, e1.none}));
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_acc;
    int base;
    int g;
    build_zz();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset o_ready low", 96'({rdy8, rdy1}), 96'd0);
    check("reset dut8 valid/first/last", 96'({ov8, f8, l8}), 96'd0);
    check("reset dut8 data", d8, 96'd0);
    check("reset dut1 valid/data", 96'({ov1, d1}), 96'd0);
`ifdef ZZ_STATS_EN
    check("reset eob outputs", 96'({ep8, en8, ep1, en1}), 96'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("o_ready after release", 96'({rdy8, rdy1}), 96'b11);
    @(posedge clk); #1;

    // 1: raster index coefficients, zigzag mode
    fill(0);
    send_block8(1'b0);
    wait_drain();

    // 2: three blocks back-to-back with downstream always ready
    waits8 = 0; gaps8 = 0; first_v_cyc = -1; gap_base = pops8; gap_arm = 1'b1;
    fill(1); send_block8(1'b0);
    t_acc = cyc;
    fill(2); send_block8(1'b1);
    fill(3); send_block8(1'b0);
    wait_drain();
    gap_arm = 1'b0;
    check("t2 input stalls", 96'(waits8), 96'd0);
    check("t2 output bubbles", 96'(gaps8), 96'd0);
    check("t2 first o_valid cycle", 96'(first_v_cyc), 96'(t_acc + 1));

    // 3: downstream stalled for 30 cycles with three blocks offered
    base = blocks8;
    ir8 = 1'b0;
    fork
      begin
        fill(4); send_block8(1'b0);
        fill(2); send_block8(1'b0);
        fill(8); send_block8(1'b1);
      end
      begin
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("t3 o_ready low with both banks full", 96'(rdy8), 96'd0);
        check("t3 blocks accepted during stall", 96'(blocks8 - base), 96'd2);
        @(posedge clk); #1;
        ir8 = 1'b1;
      end
    join
    wait_drain();

    // 6: end-of-block statistics patterns
    fill(5); send_block8(1'b0);
    fill(6); send_block8(1'b0);
    wait_drain();

    // 5a: reset after three input beats
    send8({8{12'h111}}, 1'b0);
    send8({8{12'h222}}, 1'b0);
    send8({8{12'h333}}, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5 o_ready low in reset", 96'(rdy8), 96'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5 o_ready after release", 96'(rdy8), 96'd1);
    check("t5 outputs clear", 96'({ov8, f8, l8}), 96'd0);
    @(posedge clk); #1;

    // 5b: reset while a block is draining
    base = pops8;
    fill(7); send_block8(1'b0);
    g = 0;
    while (pops8 < base + 3 && g < 100) begin @(posedge clk); #1; g++; end
    check("t5 drain started", 96'(pops8 >= base + 3), 96'd1);
    rst_n = 1'b0;
    ir8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    q8.delete();
    @(negedge clk);
    check("t5 outputs clear in reset", 96'({ov8, f8, l8}), 96'd0);
    check("t5 data clear in reset", d8, 96'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ir8 = 1'b1;
    @(negedge clk);
    check("t5 o_ready after second release", 96'(rdy8), 96'd1);
    @(posedge clk); #1;
    fill(8); send_block8(1'b1);
    fill(0); send_block8(1'b0);
    wait_drain();

    // 4: LANES=1, modes 1,0,1
    fill(1); send_block1(1'b1);
    fill(7); send_block1(1'b0);
    fill(8); send_block1(1'b1);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
